// File: rtl/rot_req_fifo.sv
// -----------------------------------------------------------------------------
// rot_req_fifo
//   First-word fall-through request FIFO that sits in front of a barrel
//   rotator.  Each entry holds a data word and its left-rotate amount; the
//   head entry drives the rotator's data and select inputs directly.
//
// Parameters
//   N : rotator select width; data word width is 2**N bits
//   D : log2 of FIFO depth; depth is 2**D entries
//
// Ports
//   clk        sole clock, rising edge
//   reset      asynchronous, active-high reset
//   in_valid   producer presents a request on in_a / in_amt
//   in_ready   FIFO can accept a request this cycle (registered state only)
//   in_a       word to be rotated
//   in_amt     left-rotate amount
//   out_valid  head entry is valid
//   out_ready  downstream rotator consumes the head entry
//   out_a      head word (0 while empty)
//   out_amt    head amount (0 while empty)
//   count      number of stored entries, 0 .. 2**D
//   full       count == 2**D
//   empty      count == 0
//   ovf        sticky: a push was attempted while full
// -----------------------------------------------------------------------------
module rot_req_fifo #(
  parameter int N = 3,
  parameter int D = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [(2**N)-1:0]   in_a,
  input  logic [N-1:0]        in_amt,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [(2**N)-1:0]   out_a,
  output logic [N-1:0]        out_amt,
  output logic [D:0]          count,
  output logic                full,
  output logic                empty,
  output logic                ovf
);

  localparam int         W         = 2 ** N;
  localparam int         DEPTH     = 2 ** D;
  localparam logic [D:0] DEPTH_CNT = DEPTH[D:0];

  typedef struct packed {
    logic [W-1:0] a;
    logic [N-1:0] amt;
  } entry_t;

  // Control state
  logic [D-1:0] wr_ptr_q, wr_ptr_d;
  logic [D-1:0] rd_ptr_q, rd_ptr_d;
  logic [D:0]   count_q,  count_d;
  logic         ovf_q,    ovf_d;

  // Storage
  entry_t mem_q [DEPTH];
  entry_t head;

  logic push;
  logic pop;

  // NOTE: every signal written here gets a default first so that no path
  // through the block leaves it unassigned, which would infer a latch.
  always_comb begin
    full      = (count_q == DEPTH_CNT);
    empty     = (count_q == '0);
    // Handshakes depend only on registered count: no out_ready -> in_ready
    // path, so a full FIFO refuses a push even in a cycle where it pops.
    in_ready  = ~full;
    out_valid = ~empty;
    push      = in_valid & in_ready;
    pop       = out_valid & out_ready;

    wr_ptr_d  = push ? wr_ptr_q + D'(1) : wr_ptr_q;
    rd_ptr_d  = pop  ? rd_ptr_q + D'(1) : rd_ptr_q;

    count_d   = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + (D+1)'(1);
      2'b01:   count_d = count_q - (D+1)'(1);
      default: count_d = count_q;
    endcase

    ovf_d     = ovf_q | (in_valid & full);

    // Stale storage is masked while empty so the rotator sees a fixed 0.
    head      = mem_q[rd_ptr_q];
    out_a     = empty ? '0 : head.a;
    out_amt   = empty ? '0 : head.amt;

    count     = count_q;
    ovf       = ovf_q;
  end

  // NOTE: sequential state is updated with non-blocking assignments so all
  // flops sample their _d values from the same pre-edge snapshot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // NOTE: the storage array is deliberately left out of reset; count and the
  // empty mask guarantee stale words are never presented after a reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{a: in_a, amt: in_amt};
    end
  end

endmodule

// File: tb/tb_rot_req_fifo.sv
// -----------------------------------------------------------------------------
// tb_rot_req_fifo
//   Directed, self-checking bench for rot_req_fifo with N=3, D=2.  Inputs are
//   driven 1 time unit after the rising edge; outputs are sampled at that
//   same point, well clear of the next active edge.
// -----------------------------------------------------------------------------
module tb_rot_req_fifo;

  localparam int N = 3;
  localparam int D = 2;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [2:0] in_amt;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_a;
  logic [2:0] out_amt;
  logic [2:0] count;
  logic       full;
  logic       empty;
  logic       ovf;

  int vectors;
  int miscompares;

  rot_req_fifo #(.N(N), .D(D)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_amt    (in_amt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_amt   (out_amt),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Reference left-rotate of an 8-bit word.
  function automatic logic [7:0] rotl(input logic [7:0] a, input logic [2:0] amt);
    logic [15:0] dbl;
    dbl = {a, a} << amt;
    return dbl[15:8];
  endfunction

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid  = 1'b0;
    in_a      = '0;
    in_amt    = '0;
    out_ready = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    #3;
    vectors++;
    if ({empty, full, in_ready, out_valid, out_a, out_amt, count, ovf} !==
        {1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 3'd0, 1'b0}) begin
      $display("FAIL reset_state: got e=%b f=%b ir=%b ov=%b a=%h amt=%0d cnt=%0d ovf=%b, expected e=1 f=0 ir=1 ov=0 a=00 amt=0 cnt=0 ovf=0",
               empty, full, in_ready, out_valid, out_a, out_amt, count, ovf);
      miscompares++;
    end
    tick();
    reset = 1'b0;
  endtask

  // Single push right after reset release; latency 1, rotator view.
  task automatic test_single();
    in_valid = 1'b1; in_a = 8'hA5; in_amt = 3'd3;
    tick();
    idle_inputs();
    vectors++;
    if ({out_valid, out_a, out_amt, count} !== {1'b1, 8'hA5, 3'd3, 3'd1}) begin
      $display("FAIL single_push: got ov=%b a=%h amt=%0d cnt=%0d, expected ov=1 a=a5 amt=3 cnt=1",
               out_valid, out_a, out_amt, count);
      miscompares++;
    end
    vectors++;
    if (rotl(out_a, out_amt) !== 8'h2D) begin
      $display("FAIL single_rotate: got %h expected 2d", rotl(out_a, out_amt));
      miscompares++;
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    vectors++;
    if ({empty, out_valid, out_a, count} !== {1'b1, 1'b0, 8'h00, 3'd0}) begin
      $display("FAIL single_pop: got e=%b ov=%b a=%h cnt=%0d, expected e=1 ov=0 a=00 cnt=0",
               empty, out_valid, out_a, count);
      miscompares++;
    end
  endtask

  // Fill, overflow attempt while full, then drain in order.
  task automatic test_fill_overflow_drain();
    logic [7:0] va [4];
    logic [2:0] vm [4];
    va = '{8'h01, 8'h02, 8'h04, 8'h80};
    vm = '{3'd0, 3'd1, 3'd2, 3'd7};
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_a = va[i]; in_amt = vm[i];
      tick();
    end
    in_valid = 1'b0;
    vectors++;
    if ({full, in_ready, count, ovf} !== {1'b1, 1'b0, 3'd4, 1'b0}) begin
      $display("FAIL fill: got f=%b ir=%b cnt=%0d ovf=%b, expected f=1 ir=0 cnt=4 ovf=0",
               full, in_ready, count, ovf);
      miscompares++;
    end

    in_valid = 1'b1; in_a = 8'hFF; in_amt = 3'd5;
    tick();
    in_valid = 1'b0;
    vectors++;
    if ({count, ovf, out_a, out_amt} !== {3'd4, 1'b1, 8'h01, 3'd0}) begin
      $display("FAIL overflow: got cnt=%0d ovf=%b a=%h amt=%0d, expected cnt=4 ovf=1 a=01 amt=0",
               count, ovf, out_a, out_amt);
      miscompares++;
    end

    out_ready = 1'b1;
    // Full with out_ready high: no same-cycle bypass.
    vectors++;
    if (in_ready !== 1'b0) begin
      $display("FAIL full_no_bypass: got in_ready=%b expected 0", in_ready);
      miscompares++;
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if ({out_valid, out_a, out_amt} !== {1'b1, va[i], vm[i]}) begin
        $display("FAIL drain_%0d: got ov=%b a=%h amt=%0d, expected ov=1 a=%h amt=%0d",
                 i, out_valid, out_a, out_amt, va[i], vm[i]);
        miscompares++;
      end
      tick();
      if (i == 0) begin
        vectors++;
        if ({in_ready, count} !== {1'b1, 3'd3}) begin
          $display("FAIL slot_freed: got ir=%b cnt=%0d expected ir=1 cnt=3", in_ready, count);
          miscompares++;
        end
      end
    end
    out_ready = 1'b0;
    vectors++;
    if ({empty, out_valid, out_a, ovf} !== {1'b1, 1'b0, 8'h00, 1'b1}) begin
      $display("FAIL drained: got e=%b ov=%b a=%h ovf=%b, expected e=1 ov=0 a=00 ovf=1",
               empty, out_valid, out_a, ovf);
      miscompares++;
    end
  endtask

  // Steady state at count=2 with simultaneous push/pop; pointers wrap.
  task automatic test_back_to_back();
    logic [10:0] model [$];
    logic [10:0] exp_e;
    model = {};
    apply_reset();
    in_valid = 1'b1; in_a = 8'h10; in_amt = 3'd1; tick(); model.push_back({8'h10, 3'd1});
    in_a = 8'h11; in_amt = 3'd2;                  tick(); model.push_back({8'h11, 3'd2});
    vectors++;
    if (count !== 3'd2) begin
      $display("FAIL b2b_prefill: got cnt=%0d expected 2", count);
      miscompares++;
    end
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_a = 8'h20 + 8'(i); in_amt = 3'(i + 3);
      exp_e = model[0];
      vectors++;
      if ({out_valid, out_a, out_amt} !== {1'b1, exp_e}) begin
        $display("FAIL b2b_head_%0d: got ov=%b a=%h amt=%0d, expected a=%h amt=%0d",
                 i, out_valid, out_a, out_amt, exp_e[10:3], exp_e[2:0]);
        miscompares++;
      end
      tick();
      void'(model.pop_front());
      model.push_back({in_a, in_amt});
      vectors++;
      if (count !== 3'd2) begin
        $display("FAIL b2b_count_%0d: got cnt=%0d expected 2", i, count);
        miscompares++;
      end
    end
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      exp_e = model.pop_front();
      vectors++;
      if ({out_valid, out_a, out_amt} !== {1'b1, exp_e}) begin
        $display("FAIL b2b_tail_%0d: got a=%h amt=%0d, expected a=%h amt=%0d",
                 i, out_a, out_amt, exp_e[10:3], exp_e[2:0]);
        miscompares++;
      end
      tick();
    end
    out_ready = 1'b0;
    vectors++;
    if (empty !== 1'b1) begin
      $display("FAIL b2b_empty: got e=%b expected 1", empty);
      miscompares++;
    end
  endtask

  // Push into empty with out_ready high: no bypass; pop on empty is a no-op.
  task automatic test_empty_simul();
    in_valid = 1'b1; in_a = 8'h5A; in_amt = 3'd6; out_ready = 1'b1;
    vectors++;
    if ({out_valid, out_a} !== {1'b0, 8'h00}) begin
      $display("FAIL empty_no_bypass: got ov=%b a=%h expected ov=0 a=00", out_valid, out_a);
      miscompares++;
    end
    tick();
    in_valid = 1'b0;
    vectors++;
    if ({count, out_valid, out_a, out_amt} !== {3'd1, 1'b1, 8'h5A, 3'd6}) begin
      $display("FAIL empty_push: got cnt=%0d ov=%b a=%h amt=%0d, expected cnt=1 ov=1 a=5a amt=6",
               count, out_valid, out_a, out_amt);
      miscompares++;
    end
    tick();
    tick();
    out_ready = 1'b0;
    vectors++;
    if ({count, empty, ovf} !== {3'd0, 1'b1, 1'b0}) begin
      $display("FAIL pop_on_empty: got cnt=%0d e=%b ovf=%b, expected cnt=0 e=1 ovf=0",
               count, empty, ovf);
      miscompares++;
    end
  endtask

  // Asynchronous reset mid-operation, then a fresh push.
  task automatic test_mid_reset();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_a = 8'h70 + 8'(i); in_amt = 3'(i);
      tick();
    end
    in_valid = 1'b1; in_a = 8'h77; in_amt = 3'd1;
    tick();
    in_valid = 1'b1; in_a = 8'hEE; tick();   // sets ovf while full
    idle_inputs();
    out_ready = 1'b1; tick(); out_ready = 1'b0; // back to count=3
    vectors++;
    if ({count, ovf} !== {3'd3, 1'b1}) begin
      $display("FAIL pre_reset: got cnt=%0d ovf=%b expected cnt=3 ovf=1", count, ovf);
      miscompares++;
    end
    reset = 1'b1;
    #1;
    vectors++;
    if ({empty, out_valid, out_a, out_amt, count, ovf} !==
        {1'b1, 1'b0, 8'h00, 3'd0, 3'd0, 1'b0}) begin
      $display("FAIL async_reset: got e=%b ov=%b a=%h amt=%0d cnt=%0d ovf=%b, expected e=1 ov=0 a=00 amt=0 cnt=0 ovf=0",
               empty, out_valid, out_a, out_amt, count, ovf);
      miscompares++;
    end
    #1;
    reset = 1'b0;
    in_valid = 1'b1; in_a = 8'h3C; in_amt = 3'd4;
    tick();
    in_valid = 1'b0;
    vectors++;
    if ({out_valid, out_a, out_amt, count} !== {1'b1, 8'h3C, 3'd4, 3'd1}) begin
      $display("FAIL post_reset_push: got ov=%b a=%h amt=%0d cnt=%0d, expected ov=1 a=3c amt=4 cnt=1",
               out_valid, out_a, out_amt, count);
      miscompares++;
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_single();
    test_fill_overflow_drain();
    test_back_to_back();
    test_empty_simul();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rot_req_fifo.md
ROT_REQ_FIFO -- requirements
Module: rot_req_fifo

Interface
REQ-001 Parameter N, default 3: rotator select width; data word width is 2**N bits.
REQ-002 Parameter D, default 2: log2 of FIFO depth; depth = 2**D entries.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  producer presents a request on in_a/in_amt.
REQ-006 in_ready  output  1  FIFO can accept a request this cycle.
REQ-007 in_a  input  2**N  word to be rotated.
REQ-008 in_amt  input  N  left-rotate amount.
REQ-009 out_valid  output  1  head entry is valid and driven to the rotator.
REQ-010 out_ready  input  1  downstream rotator stage consumes the head entry.
REQ-011 out_a  output  2**N  head word, feeds rotator data input directly.
REQ-012 out_amt  output  N  head amount, feeds rotator select input directly.
REQ-013 count  output  D+1  number of stored entries, 0 to 2**D.
REQ-014 full  output  1  count equals 2**D.
REQ-015 empty  output  1  count equals 0.
REQ-016 ovf  output  1  sticky flag: a push was attempted while full.

Function
REQ-017 Storage SHALL be 2**D entries of {in_a, in_amt}, written at wr_ptr and read at rd_ptr; both pointers are D bits wide and wrap from 2**D-1 to 0.
REQ-018 in_ready SHALL equal not full, derived from registered state only, with no combinational path from out_ready.
REQ-019 out_valid SHALL equal not empty.
REQ-020 Push SHALL occur on a clock edge where in_valid and in_ready are both 1: write entry at wr_ptr, increment wr_ptr.
REQ-021 Pop SHALL occur on a clock edge where out_valid and out_ready are both 1: increment rd_ptr.
REQ-022 count SHALL increment on push only, decrement on pop only, and remain unchanged on simultaneous push and pop.
REQ-023 The FIFO SHALL be first-word fall-through: out_a/out_amt show mem[rd_ptr] combinationally; a request pushed into an empty FIFO at edge t is presented with out_valid=1 in the cycle after edge t (latency 1).
REQ-024 When empty, out_a and out_amt SHALL be driven to 0, so the rotator output is deterministic.
REQ-025 When full, in_ready is 0 even if out_ready is 1 (no same-cycle bypass); a pop that cycle frees one slot and in_ready returns to 1 the next cycle.
REQ-026 When empty, in_valid with out_ready=1 SHALL push only; the entry is not bypassed to the output in the same cycle.
REQ-027 in_valid=1 while full SHALL leave all storage, pointers and count unchanged and SHALL set ovf to 1 at that edge.
REQ-028 ovf SHALL remain 1 until reset.
REQ-029 Entries SHALL leave in strict push order; the stored in_amt SHALL accompany its in_a unchanged.
REQ-030 out_ready=1 while empty SHALL have no effect.

Reset
REQ-031 While reset is high, the block SHALL immediately, independent of clk, force wr_ptr=0, rd_ptr=0, count=0, ovf=0, so empty=1, full=0, in_ready=1, out_valid=0, out_a=0, out_amt=0.
REQ-032 Reset asserted mid-operation SHALL discard all stored entries; storage contents need not be cleared but SHALL never be presented.
REQ-033 The first push SHALL be accepted on the first rising edge after reset deasserts.

Verification (N=3, D=2)
REQ-034 Reset, then push a=8'hA5 amt=3 with out_ready=0 -> next cycle out_valid=1, out_a=8'hA5, out_amt=3, count=1; rotator output = 8'h2D.
REQ-035 Push 4 entries (8'h01/0, 8'h02/1, 8'h04/2, 8'h80/7) with out_ready=0 -> full=1, in_ready=0; then drain with out_ready=1 -> entries appear in push order; empty=1 after 4 pops.
REQ-036 While full, in_valid=1 with a=8'hFF -> count stays 4, ovf=1; entry 8'hFF never appears at output; ovf stays 1 after draining.
REQ-037 count=2, in_valid=1 and out_ready=1 for 6 cycles -> count stays 2, outputs follow push order; pointers wrap past 3 without loss.
REQ-038 Empty FIFO, in_valid=1 and out_ready=1 in the same cycle -> out_valid=0 that cycle, count=1 next cycle.
REQ-039 Count=3, assert reset between edges -> empty=1, out_a=0, count=0 immediately without a clock edge; a push after release -> out_a equals the new word.
